// File: rtl/seq_101_rr_scheduler.sv
// Round-robin scheduler that shares one external Moore "101" detector between two word requesters.
// Each granted word is shifted MSB-first into the detector, and its z pulses are counted into a result.
module seq_101_rr_scheduler #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic             w_out,
  output logic             det_rst_n,
  input  logic             z_in,
  output logic             res_valid,
  output logic             res_chan,
  output logic [CNT_W-1:0] res_count,
  input  logic             res_ready
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t           state;
  logic             rr_last;
  logic [WIDTH-1:0] sreg;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             xfer;
  logic             gnt_chan;
  logic [WIDTH-1:0] gnt_data;

  // Grant prefers the channel that did not win last; only offered while idle.
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE) begin
      if (rr_last) begin
        if (req_valid[0])      req_ready = 2'b01;
        else if (req_valid[1]) req_ready = 2'b10;
      end else begin
        if (req_valid[1])      req_ready = 2'b10;
        else if (req_valid[0]) req_ready = 2'b01;
      end
    end
  end

  assign xfer     = |(req_ready & req_valid);
  assign gnt_chan = req_ready[1];
  assign gnt_data = gnt_chan ? req_data1 : req_data0;

  // Saturating add of the detector output.
  assign count_inc = (z_in && (count != {CNT_W{1'b1}})) ? count + CNT_W'(1) : count;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      sreg      <= '0;
      idx       <= '0;
      count     <= '0;
      w_out     <= 1'b0;
      det_rst_n <= 1'b0;
      res_valid <= 1'b0;
      res_chan  <= 1'b0;
      res_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            sreg      <= gnt_data;
            w_out     <= gnt_data[WIDTH-1];
            det_rst_n <= 1'b1;
            rr_last   <= gnt_chan;
            count     <= '0;
            idx       <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // z during bit 0 still reflects the freshly released detector, so it is skipped.
          if (idx != '0) count <= count_inc;
          if (idx == IDX_W'(WIDTH - 1)) begin
            w_out <= 1'b0;
            state <= DRAIN;
          end else begin
            w_out <= sreg[WIDTH-2];
            sreg  <= {sreg[WIDTH-2:0], 1'b0};
            idx   <= idx + IDX_W'(1);
          end
        end
        DRAIN: begin
          res_count <= count_inc;
          res_chan  <= rr_last;
          res_valid <= 1'b1;
          det_rst_n <= 1'b0;
          w_out     <= 1'b0;
          state     <= RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_101_rr_scheduler.sv
// Directed bench for seq_101_rr_scheduler with a behavioural Moore "101" detector attached.
module tb_seq_101_rr_scheduler;

  logic       Clk;
  logic       Reset;
  logic [1:0] req_valid;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] req_ready;
  logic       w_out;
  logic       det_rst_n;
  logic       z_in;
  logic       res_valid;
  logic       res_chan;
  logic [3:0] res_count;
  logic       res_ready;

  int checks;
  int errors;

  seq_101_rr_scheduler #(.WIDTH(8), .CNT_W(4)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .w_out     (w_out),
    .det_rst_n (det_rst_n),
    .z_in      (z_in),
    .res_valid (res_valid),
    .res_chan  (res_chan),
    .res_count (res_count),
    .res_ready (res_ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Moore 101 detector: 0=start, 1=seen 1, 2=seen 10, 3=seen 101 (z=1).
  logic [1:0] ds;
  always_ff @(posedge Clk or negedge det_rst_n) begin
    if (!det_rst_n) ds <= 2'd0;
    else begin
      case (ds)
        2'd0:    ds <= w_out ? 2'd1 : 2'd0;
        2'd1:    ds <= w_out ? 2'd1 : 2'd2;
        2'd2:    ds <= w_out ? 2'd3 : 2'd0;
        default: ds <= w_out ? 2'd1 : 2'd2;
      endcase
    end
  end
  assign z_in = (ds == 2'd3);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("res_valid_timeout", 32'(res_valid), 32'd1);
  endtask

  // Offer one word on a single channel and let it transfer on the next edge.
  task automatic send(input logic chan, input logic [7:0] data, input logic [1:0] exp_gnt);
    if (chan) begin req_data1 = data; req_valid = 2'b10; end
    else      begin req_data0 = data; req_valid = 2'b01; end
    #1;
    chk("grant", 32'(req_ready), 32'(exp_gnt));
    @(posedge Clk);
    #1;
    req_valid = 2'b00;
  endtask

  initial begin
    logic [7:0] pat;
    int n;
    checks = 0;
    errors = 0;
    req_valid = 2'b00;
    req_data0 = 8'h00;
    req_data1 = 8'h00;
    res_ready = 1'b0;
    Reset = 1'b1;
    #1 Reset = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_det_rst_n", 32'(det_rst_n), 32'd0);
    chk("rst_w_out", 32'(w_out), 32'd0);
    chk("rst_res_count", 32'(res_count), 32'd0);
    step();

    // Single word 1010_1000 on ch0: bit stream and exact latency.
    pat = 8'hA8;
    send(1'b0, pat, 2'b01);
    chk("shift_det_rst_n", 32'(det_rst_n), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("w_out_bit%0d", i), 32'(w_out), 32'(pat[7-i]));
      chk($sformatf("shift_no_grant%0d", i), 32'(req_ready), 32'd0);
      step();
    end
    chk("drain_w_out", 32'(w_out), 32'd0);
    chk("drain_no_result", 32'(res_valid), 32'd0);
    step();
    chk("lat_res_valid", 32'(res_valid), 32'd1);
    chk("lat_res_chan", 32'(res_chan), 32'd0);
    chk("lat_res_count", 32'(res_count), 32'd2);
    chk("result_det_rst_n", 32'(det_rst_n), 32'd0);
    res_ready = 1'b1;
    step();
    chk("accept_res_valid", 32'(res_valid), 32'd0);

    // Fresh reset so ch0 wins first, then both channels held valid.
    Reset = 1'b0;
    #2 Reset = 1'b1;
    req_data0 = 8'hA0;
    req_data1 = 8'hFF;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_res(n);
      if (k > 0) chk($sformatf("rr_period%0d", k), 32'(n), 32'd10);
      chk($sformatf("rr_chan%0d", k), 32'(res_chan), 32'(k % 2));
      chk($sformatf("rr_count%0d", k), 32'(res_count), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k == 3) req_valid = 2'b00;
      step();
    end

    // 0x05 then 0xA0: the 1101 across the word boundary must not add a match.
    send(1'b0, 8'h05, 2'b01);
    wait_res(n);
    chk("bnd_count_05", 32'(res_count), 32'd1);
    step();
    send(1'b0, 8'hA0, 2'b01);
    wait_res(n);
    chk("bnd_count_a0", 32'(res_count), 32'd1);
    step();

    // 0x55 on ch1 with the consumer stalled; a competing request must wait.
    res_ready = 1'b0;
    send(1'b1, 8'h55, 2'b10);
    wait_res(n);
    req_data0 = 8'h11;
    req_valid = 2'b01;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall_valid%0d", c), 32'(res_valid), 32'd1);
      chk($sformatf("stall_count%0d", c), 32'(res_count), 32'd3);
      chk($sformatf("stall_chan%0d", c), 32'(res_chan), 32'd1);
      chk($sformatf("stall_ready%0d", c), 32'(req_ready), 32'd0);
      step();
    end
    req_valid = 2'b00;
    res_ready = 1'b1;
    step();
    chk("stall_accept", 32'(res_valid), 32'd0);

    // Reset during SHIFT bit 4 discards the word; the next ch1 word starts clean.
    send(1'b0, 8'hAD, 2'b01);
    for (int i = 0; i < 4; i++) step();
    chk("mid_shift_w_out", 32'(w_out), 32'd1);
    Reset = 1'b0;
    #1;
    chk("mid_rst_w_out", 32'(w_out), 32'd0);
    chk("mid_rst_det_rst_n", 32'(det_rst_n), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    #2 Reset = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("mid_rst_no_result", 32'(res_valid), 32'd0);
    send(1'b1, 8'h50, 2'b10);
    wait_res(n);
    chk("post_rst_chan", 32'(res_chan), 32'd1);
    chk("post_rst_count", 32'(res_count), 32'd1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
